// File: rtl/nasti2wb.sv
`default_nettype none
// ============================================================================
// Module  : nasti2wb
// Purpose : NASTI (AXI4) slave to Wishbone B4 classic master bridge with a
//           single transaction in flight; each burst beat is one WB cycle.
// Revision: 1.0  initial release
// ============================================================================
module nasti2wb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NASTI_ID_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NASTI_ID_WIDTH-1:0] s_nasti_awid,
  input  logic [ADDR_WIDTH-1:0]     s_nasti_awaddr,
  input  logic [7:0]                s_nasti_awlen,
  input  logic [2:0]                s_nasti_awsize,
  input  logic [1:0]                s_nasti_awburst,
  input  logic                      s_nasti_awvalid,
  output logic                      s_nasti_awready,
  input  logic [DATA_WIDTH-1:0]     s_nasti_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_nasti_wstrb,
  input  logic                      s_nasti_wlast,
  input  logic                      s_nasti_wvalid,
  output logic                      s_nasti_wready,
  output logic [NASTI_ID_WIDTH-1:0] s_nasti_bid,
  output logic [1:0]                s_nasti_bresp,
  output logic                      s_nasti_bvalid,
  input  logic                      s_nasti_bready,
  input  logic [NASTI_ID_WIDTH-1:0] s_nasti_arid,
  input  logic [ADDR_WIDTH-1:0]     s_nasti_araddr,
  input  logic [7:0]                s_nasti_arlen,
  input  logic [2:0]                s_nasti_arsize,
  input  logic [1:0]                s_nasti_arburst,
  input  logic                      s_nasti_arvalid,
  output logic                      s_nasti_arready,
  output logic [NASTI_ID_WIDTH-1:0] s_nasti_rid,
  output logic [DATA_WIDTH-1:0]     s_nasti_rdata,
  output logic [1:0]                s_nasti_rresp,
  output logic                      s_nasti_rlast,
  output logic                      s_nasti_rvalid,
  input  logic                      s_nasti_rready,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic [2:0]                wb_cti_o,
  output logic [1:0]                wb_bte_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i
);

  localparam int         c_sel_w     = DATA_WIDTH / 8;
  localparam logic [2:0] c_max_size  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] c_burst_inc = 2'b01;
  localparam logic [1:0] c_okay      = 2'b00;
  localparam logic [1:0] c_slverr    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_WB   = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_WB   = 3'd4,
    S_RD_DATA = 3'd5
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_lww, w_lww_nxt;
  logic [NASTI_ID_WIDTH-1:0] r_id, w_id_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr, w_addr_nxt;
  logic [7:0]                r_cnt, w_cnt_nxt;
  logic [2:0]                r_size, w_size_nxt;
  logic [1:0]                r_burst, w_burst_nxt;
  logic                      r_err, w_err_nxt;
  logic                      r_bad, w_bad_nxt;
  logic                      r_awready, w_awready_nxt;
  logic                      r_arready, w_arready_nxt;
  logic                      r_wready, w_wready_nxt;
  logic                      r_bvalid, w_bvalid_nxt;
  logic [1:0]                r_bresp, w_bresp_nxt;
  logic                      r_rvalid, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0]     r_rdata, w_rdata_nxt;
  logic [1:0]                r_rresp, w_rresp_nxt;
  logic                      r_rlast, w_rlast_nxt;
  logic                      r_cyc, w_cyc_nxt;
  logic                      r_we, w_we_nxt;
  logic [DATA_WIDTH-1:0]     r_dat, w_dat_nxt;
  logic [c_sel_w-1:0]        r_sel, w_sel_nxt;
  logic [2:0]                r_cti, w_cti_nxt;

  logic                      w_ack_any, w_ack_err, w_aw_bad, w_ar_bad, w_aw_pick;
  logic [ADDR_WIDTH-1:0]     w_step, w_addr_step;
  logic                      w_unused_wlast;

  assign w_unused_wlast = s_nasti_wlast;
  assign w_ack_any      = wb_ack_i | wb_err_i | wb_rty_i;
  assign w_ack_err      = wb_err_i | wb_rty_i;
  // WRAP and the reserved burst code both have bit 1 set
  assign w_aw_bad       = s_nasti_awburst[1] | (s_nasti_awsize > c_max_size);
  assign w_ar_bad       = s_nasti_arburst[1] | (s_nasti_arsize > c_max_size);
  assign w_aw_pick      = s_nasti_awvalid & (~s_nasti_arvalid | ~r_lww);
  assign w_step         = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << r_size;
  assign w_addr_step    = (r_burst == c_burst_inc) ? r_addr + w_step : r_addr;

  function automatic logic [2:0] f_cti(input logic [1:0] burst, input logic [7:0] cnt);
    if (burst != c_burst_inc) return 3'b000;
    return (cnt == 8'd0) ? 3'b111 : 3'b010;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_lww_nxt     = r_lww;
    w_id_nxt      = r_id;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_size_nxt    = r_size;
    w_burst_nxt   = r_burst;
    w_err_nxt     = r_err;
    w_bad_nxt     = r_bad;
    w_awready_nxt = r_awready;
    w_arready_nxt = r_arready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_rvalid_nxt  = r_rvalid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_rlast_nxt   = r_rlast;
    w_cyc_nxt     = r_cyc;
    w_we_nxt      = r_we;
    w_dat_nxt     = r_dat;
    w_sel_nxt     = r_sel;
    w_cti_nxt     = r_cti;
    case (r_state)
      S_IDLE: begin
        if (r_awready && s_nasti_awvalid) begin
          w_awready_nxt = 1'b0;
          w_id_nxt      = s_nasti_awid;
          w_addr_nxt    = s_nasti_awaddr;
          w_cnt_nxt     = s_nasti_awlen;
          w_size_nxt    = s_nasti_awsize;
          w_burst_nxt   = s_nasti_awburst;
          w_bad_nxt     = w_aw_bad;
          w_err_nxt     = 1'b0;
          w_lww_nxt     = 1'b1;
          w_wready_nxt  = 1'b1;
          w_state_nxt   = S_WR_DATA;
        end else if (r_arready && s_nasti_arvalid) begin
          w_arready_nxt = 1'b0;
          w_id_nxt      = s_nasti_arid;
          w_addr_nxt    = s_nasti_araddr;
          w_cnt_nxt     = s_nasti_arlen;
          w_size_nxt    = s_nasti_arsize;
          w_burst_nxt   = s_nasti_arburst;
          w_bad_nxt     = w_ar_bad;
          w_lww_nxt     = 1'b0;
          w_cyc_nxt     = ~w_ar_bad;
          w_we_nxt      = 1'b0;
          w_sel_nxt     = {c_sel_w{1'b1}};
          w_cti_nxt     = f_cti(s_nasti_arburst, s_nasti_arlen);
          w_state_nxt   = S_RD_WB;
        end else begin
          // Ready is re-decided every idle cycle so at most one channel is offered
          w_awready_nxt = w_aw_pick;
          w_arready_nxt = s_nasti_arvalid & ~w_aw_pick;
        end
      end
      S_WR_DATA: begin
        if (r_wready && s_nasti_wvalid) begin
          if (r_bad) begin
            w_err_nxt = 1'b1;
            if (r_cnt == 8'd0) begin
              w_wready_nxt = 1'b0;
              w_bvalid_nxt = 1'b1;
              w_bresp_nxt  = c_slverr;
              w_state_nxt  = S_WR_RESP;
            end else begin
              w_cnt_nxt = r_cnt - 8'd1;
            end
          end else begin
            w_wready_nxt = 1'b0;
            w_dat_nxt    = s_nasti_wdata;
            w_sel_nxt    = s_nasti_wstrb;
            w_cyc_nxt    = 1'b1;
            w_we_nxt     = 1'b1;
            w_cti_nxt    = f_cti(r_burst, r_cnt);
            w_state_nxt  = S_WR_WB;
          end
        end
      end
      S_WR_WB: begin
        if (w_ack_any) begin
          w_cyc_nxt = 1'b0;
          w_we_nxt  = 1'b0;
          w_err_nxt = r_err | w_ack_err;
          if (r_cnt == 8'd0) begin
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = (r_err | w_ack_err) ? c_slverr : c_okay;
            w_state_nxt  = S_WR_RESP;
          end else begin
            w_cnt_nxt    = r_cnt - 8'd1;
            w_addr_nxt   = w_addr_step;
            w_wready_nxt = 1'b1;
            w_state_nxt  = S_WR_DATA;
          end
        end
      end
      S_WR_RESP: begin
        if (s_nasti_bready) begin
          w_bvalid_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end
      S_RD_WB: begin
        if (r_bad) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = '0;
          w_rresp_nxt  = c_slverr;
          w_rlast_nxt  = (r_cnt == 8'd0);
          w_state_nxt  = S_RD_DATA;
        end else if (w_ack_any) begin
          w_cyc_nxt    = 1'b0;
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = wb_dat_i;
          w_rresp_nxt  = w_ack_err ? c_slverr : c_okay;
          w_rlast_nxt  = (r_cnt == 8'd0);
          w_state_nxt  = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (s_nasti_rready) begin
          w_rvalid_nxt = 1'b0;
          if (r_rlast) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = r_cnt - 8'd1;
            w_addr_nxt  = w_addr_step;
            w_cyc_nxt   = ~r_bad;
            w_cti_nxt   = f_cti(r_burst, r_cnt - 8'd1);
            w_state_nxt = S_RD_WB;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lww     <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_bad     <= 1'b0;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_cti     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lww     <= w_lww_nxt;
      r_id      <= w_id_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_size    <= w_size_nxt;
      r_burst   <= w_burst_nxt;
      r_err     <= w_err_nxt;
      r_bad     <= w_bad_nxt;
      r_awready <= w_awready_nxt;
      r_arready <= w_arready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rlast   <= w_rlast_nxt;
      r_cyc     <= w_cyc_nxt;
      r_we      <= w_we_nxt;
      r_dat     <= w_dat_nxt;
      r_sel     <= w_sel_nxt;
      r_cti     <= w_cti_nxt;
    end
  end

  assign s_nasti_awready = r_awready;
  assign s_nasti_arready = r_arready;
  assign s_nasti_wready  = r_wready;
  assign s_nasti_bid     = r_id;
  assign s_nasti_bresp   = r_bresp;
  assign s_nasti_bvalid  = r_bvalid;
  assign s_nasti_rid     = r_id;
  assign s_nasti_rdata   = r_rdata;
  assign s_nasti_rresp   = r_rresp;
  assign s_nasti_rlast   = r_rlast;
  assign s_nasti_rvalid  = r_rvalid;
  assign wb_cyc_o        = r_cyc;
  assign wb_stb_o        = r_cyc;
  assign wb_we_o         = r_we;
  assign wb_adr_o        = r_addr;
  assign wb_dat_o        = r_dat;
  assign wb_sel_o        = r_sel;
  assign wb_cti_o        = r_cti;
  assign wb_bte_o        = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_nasti2wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_nasti2wb
// Purpose : Self-checking bench for nasti2wb against a transaction-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_nasti2wb;

  logic        clk, rst;
  logic [0:0]  s_nasti_awid, s_nasti_bid, s_nasti_arid, s_nasti_rid;
  logic [31:0] s_nasti_awaddr, s_nasti_araddr, s_nasti_wdata, s_nasti_rdata;
  logic [7:0]  s_nasti_awlen, s_nasti_arlen;
  logic [2:0]  s_nasti_awsize, s_nasti_arsize;
  logic [1:0]  s_nasti_awburst, s_nasti_arburst, s_nasti_bresp, s_nasti_rresp;
  logic        s_nasti_awvalid, s_nasti_awready, s_nasti_wlast, s_nasti_wvalid, s_nasti_wready;
  logic [3:0]  s_nasti_wstrb;
  logic        s_nasti_bvalid, s_nasti_bready, s_nasti_arvalid, s_nasti_arready;
  logic        s_nasti_rlast, s_nasti_rvalid, s_nasti_rready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;

  nasti2wb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NASTI_ID_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .s_nasti_awid(s_nasti_awid), .s_nasti_awaddr(s_nasti_awaddr), .s_nasti_awlen(s_nasti_awlen),
    .s_nasti_awsize(s_nasti_awsize), .s_nasti_awburst(s_nasti_awburst),
    .s_nasti_awvalid(s_nasti_awvalid), .s_nasti_awready(s_nasti_awready),
    .s_nasti_wdata(s_nasti_wdata), .s_nasti_wstrb(s_nasti_wstrb), .s_nasti_wlast(s_nasti_wlast),
    .s_nasti_wvalid(s_nasti_wvalid), .s_nasti_wready(s_nasti_wready),
    .s_nasti_bid(s_nasti_bid), .s_nasti_bresp(s_nasti_bresp),
    .s_nasti_bvalid(s_nasti_bvalid), .s_nasti_bready(s_nasti_bready),
    .s_nasti_arid(s_nasti_arid), .s_nasti_araddr(s_nasti_araddr), .s_nasti_arlen(s_nasti_arlen),
    .s_nasti_arsize(s_nasti_arsize), .s_nasti_arburst(s_nasti_arburst),
    .s_nasti_arvalid(s_nasti_arvalid), .s_nasti_arready(s_nasti_arready),
    .s_nasti_rid(s_nasti_rid), .s_nasti_rdata(s_nasti_rdata), .s_nasti_rresp(s_nasti_rresp),
    .s_nasti_rlast(s_nasti_rlast), .s_nasti_rvalid(s_nasti_rvalid), .s_nasti_rready(s_nasti_rready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] rdat;
  } wbacc_t;

  wbacc_t obs[$];        // WB accesses seen by the slave model
  int     plan_code[$];  // per-access response: 0 ack, 1 err, 2 rty
  bit     slave_en = 1'b1;
  bit     busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL timeout %s: no handshake within bound", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Wishbone slave: random wait states, scripted responses, random read data
  initial begin : slave
    int     wt, code;
    logic [31:0] rd;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 0;
    wt = 0; code = 0; rd = 0;
    forever begin
      @(posedge clk); #1;
      if (wb_ack_i || wb_err_i || wb_rty_i) begin
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      end else if (wb_cyc_o && slave_en) begin
        if (!busy) begin
          busy = 1'b1;
          wt   = $urandom_range(0, 2);
          code = (plan_code.size() > 0) ? plan_code.pop_front() : 0;
          rd   = $urandom;
        end
        if (wt > 0) wt--;
        else begin
          chk("wb_stb_eq_cyc", wb_stb_o, wb_cyc_o);
          chk("wb_bte", wb_bte_o, 2'b00);
          obs.push_back('{wb_adr_o, wb_we_o, wb_dat_o, wb_sel_o, wb_cti_o, rd});
          wb_dat_i = rd;
          wb_ack_i = (code == 0);
          wb_err_i = (code == 1);
          wb_rty_i = (code == 2);
          busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    tmo("global");
  end

  // One complete NASTI transaction, checked against the beat-level rules
  task automatic run_txn(input bit wr, input logic [0:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         input logic [7:0] mask, input bit rty,
                         output logic [1:0] resp, output int nwb);
    int          code[256];
    logic [31:0] wd[256];
    logic [3:0]  ws[256];
    bit          bad, any_err;
    int          n, nb, exp_n;
    logic [31:0] ea;
    bad = burst[1] || (size > 3'd2);
    nb = int'(len) + 1;
    any_err = 0;
    obs.delete();
    plan_code.delete();
    for (int i = 0; i < nb; i++) begin
      code[i] = (i < 8 && mask[i]) ? (rty ? 2 : 1) : 0;
      any_err |= (code[i] != 0);
      wd[i] = $urandom;
      ws[i] = 4'($urandom_range(0, 15));
      if (!bad) plan_code.push_back(code[i]);
    end
    resp = 2'b00;
    if (wr) begin
      s_nasti_awid = id; s_nasti_awaddr = addr; s_nasti_awlen = len;
      s_nasti_awsize = size; s_nasti_awburst = burst; s_nasti_awvalid = 1;
      n = 0;
      while (!s_nasti_awready) begin if (++n > 50) tmo("awready"); @(posedge clk); #1; end
      @(posedge clk); #1;
      s_nasti_awvalid = 0;
      for (int i = 0; i < nb; i++) begin
        s_nasti_wvalid = 0;
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        s_nasti_wdata = wd[i]; s_nasti_wstrb = ws[i]; s_nasti_wlast = (i == nb - 1);
        s_nasti_wvalid = 1;
        n = 0;
        while (!s_nasti_wready) begin if (++n > 50) tmo("wready"); @(posedge clk); #1; end
        @(posedge clk); #1;
      end
      s_nasti_wvalid = 0;
      n = 0;
      while (!s_nasti_bvalid) begin if (++n > 50) tmo("bvalid"); @(posedge clk); #1; end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      s_nasti_bready = 1;
      chk("bvalid_held", s_nasti_bvalid, 1'b1);
      chk("bid", s_nasti_bid, id);
      chk("bresp", s_nasti_bresp, (bad || any_err) ? 2'b10 : 2'b00);
      resp = s_nasti_bresp;
      @(posedge clk); #1;
      s_nasti_bready = 0;
      chk("bvalid_drop", s_nasti_bvalid, 1'b0);
    end else begin
      s_nasti_arid = id; s_nasti_araddr = addr; s_nasti_arlen = len;
      s_nasti_arsize = size; s_nasti_arburst = burst; s_nasti_arvalid = 1;
      n = 0;
      while (!s_nasti_arready) begin if (++n > 50) tmo("arready"); @(posedge clk); #1; end
      @(posedge clk); #1;
      s_nasti_arvalid = 0;
      for (int i = 0; i < nb; i++) begin
        n = 0;
        while (!s_nasti_rvalid) begin if (++n > 50) tmo("rvalid"); @(posedge clk); #1; end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_nasti_rready = 1;
        chk("rid", s_nasti_rid, id);
        chk("rlast", s_nasti_rlast, (i == nb - 1));
        if (bad) begin
          chk("rresp_bad", s_nasti_rresp, 2'b10);
          chk("rdata_bad", s_nasti_rdata, 32'h0);
        end else begin
          chk("rresp", s_nasti_rresp, (code[i] != 0) ? 2'b10 : 2'b00);
          chk("rd_seen", (obs.size() > i), 1'b1);
          if (obs.size() > i) chk("rdata", s_nasti_rdata, obs[i].rdat);
        end
        resp |= s_nasti_rresp;
        @(posedge clk); #1;
        s_nasti_rready = 0;
      end
    end
    exp_n = bad ? 0 : nb;
    chk("wb_count", obs.size(), exp_n);
    for (int i = 0; i < obs.size() && i < exp_n; i++) begin
      ea = (burst == 2'b01) ? addr + 32'(i) * (32'd1 << size) : addr;
      chk("wb_adr", obs[i].adr, ea);
      chk("wb_we", obs[i].we, wr);
      chk("wb_sel", obs[i].sel, wr ? ws[i] : 4'hF);
      chk("wb_cti", obs[i].cti, (burst == 2'b01) ? ((i == nb - 1) ? 3'b111 : 3'b010) : 3'b000);
      if (wr) chk("wb_dat", obs[i].dat, wd[i]);
    end
    nwb = obs.size();
  endtask

  // Present AW and AR together; the expected winner is completed, the loser withdrawn
  task automatic arb(input bit exp_w, input logic [31:0] a);
    int n;
    logic [1:0] r;
    int w;
    s_nasti_awid = 0; s_nasti_awaddr = a; s_nasti_awlen = 0; s_nasti_awsize = 2;
    s_nasti_awburst = 1; s_nasti_awvalid = 1;
    s_nasti_arid = 1; s_nasti_araddr = a + 4; s_nasti_arlen = 0; s_nasti_arsize = 2;
    s_nasti_arburst = 1; s_nasti_arvalid = 1;
    n = 0;
    while (!(s_nasti_awready || s_nasti_arready)) begin
      if (++n > 20) tmo("arb");
      @(posedge clk); #1;
    end
    chk("arb_awready", s_nasti_awready, exp_w);
    chk("arb_arready", s_nasti_arready, !exp_w);
    if (exp_w) begin
      s_nasti_arvalid = 0;
      run_txn(1, 0, a, 0, 2, 1, 0, 0, r, w);
    end else begin
      s_nasti_awvalid = 0;
      run_txn(0, 1, a + 4, 0, 2, 1, 0, 0, r, w);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  mask;
    bit          rty;
    logic [1:0]  exp_resp;
    int          exp_wb;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    logic [1:0] resp;
    int         nwb, n;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 8'd0,   3'd2, 2'b01, 8'h00, 1'b0, 2'b00, 1};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_01FC, 8'd3,   3'd2, 2'b01, 8'h00, 1'b0, 2'b00, 4};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 8'd1,   3'd2, 2'b01, 8'h01, 1'b0, 2'b10, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0080, 8'd1,   3'd2, 2'b10, 8'h00, 1'b0, 2'b10, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 8'd2,   3'd3, 2'b01, 8'h00, 1'b0, 2'b10, 0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0044, 8'd2,   3'd2, 2'b00, 8'h00, 1'b0, 2'b00, 3};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 8'd1,   3'd2, 2'b01, 8'h00, 1'b0, 2'b00, 2};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0020, 8'd1,   3'd1, 2'b01, 8'h02, 1'b1, 2'b10, 2};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_1000, 8'd255, 3'd2, 2'b01, 8'h00, 1'b0, 2'b00, 256};

    rst = 1;
    s_nasti_awvalid = 0; s_nasti_wvalid = 0; s_nasti_arvalid = 0;
    s_nasti_bready = 0; s_nasti_rready = 0;
    s_nasti_awid = 0; s_nasti_awaddr = 0; s_nasti_awlen = 0; s_nasti_awsize = 0; s_nasti_awburst = 0;
    s_nasti_arid = 0; s_nasti_araddr = 0; s_nasti_arlen = 0; s_nasti_arsize = 0; s_nasti_arburst = 0;
    s_nasti_wdata = 0; s_nasti_wstrb = 0; s_nasti_wlast = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_awready", s_nasti_awready, 0);
    chk("rst_arready", s_nasti_arready, 0);
    chk("rst_wready", s_nasti_wready, 0);
    chk("rst_bvalid", s_nasti_bvalid, 0);
    chk("rst_rvalid", s_nasti_rvalid, 0);
    chk("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    chk("rst_adr", wb_adr_o, 0);

    // Round-robin from reset: write, read, write, read
    arb(1'b1, 32'h0000_0300);
    arb(1'b0, 32'h0000_0310);
    arb(1'b1, 32'h0000_0320);
    arb(1'b0, 32'h0000_0330);

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].wr, vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size,
              vecs[v].burst, vecs[v].mask, vecs[v].rty, resp, nwb);
      chk($sformatf("vec%0d_resp", v), resp, vecs[v].exp_resp);
      chk($sformatf("vec%0d_nwb", v), nwb, vecs[v].exp_wb);
    end

    // Reset while a read strobe is outstanding
    slave_en = 0;
    s_nasti_arid = 1; s_nasti_araddr = 32'h40; s_nasti_arlen = 2; s_nasti_arsize = 2;
    s_nasti_arburst = 1; s_nasti_arvalid = 1;
    n = 0;
    while (!s_nasti_arready) begin if (++n > 50) tmo("rstmid_arready"); @(posedge clk); #1; end
    @(posedge clk); #1;
    s_nasti_arvalid = 0;
    chk("rd_stb_latency", wb_stb_o, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    chk("rd_stb_hold", wb_stb_o, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rstmid_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("rstmid_rvalid", s_nasti_rvalid, 1'b0);
    busy = 0;
    slave_en = 1;
    repeat (4) begin @(posedge clk); #1; end
    chk("rstmid_quiet", {s_nasti_rvalid, wb_cyc_o, s_nasti_bvalid}, 3'b000);
    run_txn(1, 0, 32'h0000_0500, 0, 2, 1, 0, 0, resp, nwb);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [1:0] b;
      b = 2'($urandom_range(0, 9) < 2 ? 2 : ($urandom_range(0, 3) == 0 ? 0 : 1));
      run_txn(1'($urandom), 1'($urandom), $urandom, 8'($urandom_range(0, 7)),
              3'($urandom_range(0, 3)), b, 8'($urandom & $urandom), 1'($urandom),
              resp, nwb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
